// File: rtl/rx_frame_pkg.sv
// Shared types, default characters and digit-slice helper for the RX frame assembler.
package rx_frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int         CHAR_W    = 8;
  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_ESC  = 8'h1B;

  // Bit offset of digit k inside a flattened frame of w-bit characters.
  function automatic int digit_slice(input int k, input int w = CHAR_W);
    return k * w;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter for the RX frame assembler; only built with RX_FRAME_TIMEOUT_EN.
// expire is a combinational pulse on the edge that completes TIMEOUT_CYC idle cycles.
`ifdef RX_FRAME_TIMEOUT_EN
module rx_gap_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int               GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] LAST  = GAP_W'(TIMEOUT_CYC - 1);

  logic [GAP_W-1:0] gap;

  // A byte arriving on the expiry edge wins over the timeout.
  assign expire = run && !kick && (gap == LAST);

  always_ff @(posedge clk) begin
    if (!rstn || !run || kick) begin
      gap <= '0;
    end else if (gap != LAST) begin
      gap <= gap + GAP_W'(1);
    end
  end

endmodule
`endif

// File: rtl/rx_frame_assembler.sv
// Collects UART RX bytes MSB-first into an N-digit frame and commits it atomically to digits_o.
// Optional inter-byte timeout enabled by defining RX_FRAME_TIMEOUT_EN.
module rx_frame_assembler
  import rx_frame_pkg::*;
#(
  parameter int                NUM_DIGITS  = 8,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR   = DATA_W'(CHAR_ZERO),
  parameter logic [DATA_W-1:0] TERM_CHAR   = DATA_W'(CHAR_CR),
  parameter logic [DATA_W-1:0] CLR_CHAR    = DATA_W'(CHAR_ESC),
  parameter int                AUTO_COMMIT = 1,
  parameter int                TIMEOUT_CYC = 100000,
  localparam int               CNT_W       = $clog2(NUM_DIGITS + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DATA_W-1:0]            r_data,
  input  logic                         r_valid,
  output logic [NUM_DIGITS*DATA_W-1:0] digits_o,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         busy,
  output logic [CNT_W-1:0]             fill_cnt,
  output logic                         timeout
);

  localparam int                 FRAME_W = NUM_DIGITS * DATA_W;
  localparam logic [CNT_W-1:0]   FULL    = CNT_W'(NUM_DIGITS);
  localparam logic [FRAME_W-1:0] BLANK   = {NUM_DIGITS{FILL_CHAR}};

  state_t             state;
  logic [FRAME_W-1:0] work;
  logic [FRAME_W-1:0] work_ins;
  logic               is_term, is_clr, has_room, last_slot, expire;

  assign is_term   = (r_data == TERM_CHAR);
  assign is_clr    = (r_data == CLR_CHAR);
  assign has_room  = (fill_cnt < FULL);
  assign last_slot = (fill_cnt == FULL - CNT_W'(1));

  // Working buffer with the incoming byte placed at the next MSB-first slot.
  always_comb begin
    work_ins = work;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(fill_cnt) == NUM_DIGITS - 1 - k) begin
        work_ins[digit_slice(k, DATA_W) +: DATA_W] = r_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      fill_cnt   <= '0;
      work       <= BLANK;
      digits_o   <= BLANK;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (r_valid && is_clr) begin
        state    <= IDLE;
        busy     <= 1'b0;
        fill_cnt <= '0;
        work     <= BLANK;
      end else if (r_valid && is_term) begin
        if (state == FILL) begin
          digits_o   <= work;
          frame_done <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
          fill_cnt   <= '0;
          work       <= BLANK;
        end
      end else if (r_valid && has_room) begin
        if (AUTO_COMMIT != 0 && last_slot) begin
          digits_o   <= work_ins;
          frame_done <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
          fill_cnt   <= '0;
          work       <= BLANK;
        end else begin
          work     <= work_ins;
          fill_cnt <= fill_cnt + CNT_W'(1);
          state    <= FILL;
          busy     <= 1'b1;
        end
      end else if (r_valid) begin
        overrun <= 1'b1;
      end else if (expire) begin
        state    <= IDLE;
        busy     <= 1'b0;
        fill_cnt <= '0;
        work     <= BLANK;
      end
    end
  end

`ifdef RX_FRAME_TIMEOUT_EN
  rx_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .rstn  (rstn),
    .run   (state == FILL),
    .kick  (r_valid),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rstn) timeout <= 1'b0;
    else       timeout <= expire;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: auto-commit and explicit-commit instances share one stimulus stream
// and are checked every cycle against an array-based frame model.
module tb_rx_frame_assembler;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           r_valid = 1'b0;
  logic [W-1:0]   r_data = '0;

  logic [N*W-1:0] dig_a, dig_m;
  logic           done_a, done_m, ovr_a, ovr_m, busy_a, busy_m, to_a, to_m;
  logic [3:0]     cnt_a, cnt_m;

  always #5 clk = ~clk;

  rx_frame_assembler #(.NUM_DIGITS(N), .DATA_W(W), .AUTO_COMMIT(1), .TIMEOUT_CYC(TO)) dut_auto (
    .clk(clk), .rstn(rstn), .r_data(r_data), .r_valid(r_valid),
    .digits_o(dig_a), .frame_done(done_a), .overrun(ovr_a), .busy(busy_a),
    .fill_cnt(cnt_a), .timeout(to_a)
  );

  rx_frame_assembler #(.NUM_DIGITS(N), .DATA_W(W), .AUTO_COMMIT(0), .TIMEOUT_CYC(TO)) dut_man (
    .clk(clk), .rstn(rstn), .r_data(r_data), .r_valid(r_valid),
    .digits_o(dig_m), .frame_done(done_m), .overrun(ovr_m), .busy(busy_m),
    .fill_cnt(cnt_m), .timeout(to_m)
  );

  // Reference model: index 0 = auto-commit instance, 1 = explicit-commit instance.
  logic [7:0]     mq   [2][N];
  int             mlen [2];
  int             gap  [2];
  logic [N*W-1:0] e_dig  [2];
  logic           e_done [2];
  logic           e_ovr  [2];
  logic           e_to   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic commit(input int k);
    for (int i = 0; i < N; i++)
      e_dig[k][(N-1-i)*W +: W] = (i < mlen[k]) ? mq[k][i] : 8'h30;
    e_done[k] = 1'b1;
    mlen[k]   = 0;
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      e_done[k] = 1'b0;
      e_to[k]   = 1'b0;
      if (rst) begin
        mlen[k]  = 0;
        gap[k]   = 0;
        e_ovr[k] = 1'b0;
        e_dig[k] = {N{8'h30}};
      end else if (v) begin
        gap[k] = 0;
        if (d == 8'h1B) begin
          mlen[k] = 0;
        end else if (d == 8'h0D) begin
          if (mlen[k] > 0) commit(k);
        end else if (mlen[k] < N) begin
          mq[k][mlen[k]] = d;
          mlen[k]++;
          if (k == 0 && mlen[k] == N) commit(k);
        end else begin
          e_ovr[k] = 1'b1;
        end
      end
`ifdef RX_FRAME_TIMEOUT_EN
      else if (mlen[k] > 0) begin
        gap[k]++;
        if (gap[k] == TO) begin
          mlen[k] = 0;
          gap[k]  = 0;
          e_to[k] = 1'b1;
        end
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("auto.digits",  dig_a,         e_dig[0]);
    chk("auto.done",    64'(done_a),   64'(e_done[0]));
    chk("auto.overrun", 64'(ovr_a),    64'(e_ovr[0]));
    chk("auto.busy",    64'(busy_a),   64'(mlen[0] > 0));
    chk("auto.fill",    64'(cnt_a),    64'(mlen[0]));
    chk("auto.timeout", 64'(to_a),     64'(e_to[0]));
    chk("man.digits",   dig_m,         e_dig[1]);
    chk("man.done",     64'(done_m),   64'(e_done[1]));
    chk("man.overrun",  64'(ovr_m),    64'(e_ovr[1]));
    chk("man.busy",     64'(busy_m),   64'(mlen[1] > 0));
    chk("man.fill",     64'(cnt_m),    64'(mlen[1]));
    chk("man.timeout",  64'(to_m),     64'(e_to[1]));
  endtask

  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    @(negedge clk);
    rstn    = ~rst;
    r_valid = v;
    r_data  = d;
    @(posedge clk);
    step_no++;
    model_edge(rst, v, d);
    #1;
    check_all();
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
  endtask

  function automatic logic [7:0] rnd_char();
    int r;
    r = $urandom_range(99);
    if (r < 10) return 8'h0D;
    if (r < 15) return 8'h1B;
    if (r < 80) return 8'h30 + 8'($urandom_range(9));
    return 8'h41 + 8'($urandom_range(25));
  endfunction

  initial begin
    // Reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Full frame: auto instance commits on the 8th byte, manual one waits for CR
    send("12345678");
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h0D);
    step(1'b0, 1'b0, 8'h00);

    // Partial frame padded on CR
    send("42");
    step(1'b0, 1'b1, 8'h0D);
    step(1'b0, 1'b0, 8'h00);

    // ESC discards, then a one-digit frame
    send("99");
    step(1'b0, 1'b1, 8'h1B);
    send("7");
    step(1'b0, 1'b1, 8'h0D);

    // Overrun on the manual instance, back-to-back frames on the auto one
    send("ABCDEFGHI");
    step(1'b0, 1'b1, 8'h0D);
    step(1'b0, 1'b0, 8'h00);

    // Idle gap: keep-alive byte on the 15th idle cycle, then a full timeout window
    send("5");
    repeat (14) step(1'b0, 1'b0, 8'h00);
    send("6");
    repeat (17) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h0D);
    step(1'b0, 1'b0, 8'h00);

    // Reset coinciding with a valid byte mid-frame
    send("123");
    step(1'b1, 1'b1, 8'h34);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h0D);

    // Randomized traffic with idle stretches and rare resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        step(1'b1, 1'($urandom_range(1)), rnd_char());
      end else if ($urandom_range(49) == 0) begin
        repeat ($urandom_range(20, 10)) step(1'b0, 1'b0, 8'h00);
      end else begin
        step(1'b0, 1'($urandom_range(99) < 60), rnd_char());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
